keypad_entry_controller: RTL and testbench

KEYPAD_ENTRY_CONTROLLER -- requirements
Module: keypad_entry_controller

---
 rtl/calc_pkg.sv | 34 +++
 rtl/entry_timeout_counter.sv | 35 +++
 rtl/keypad_entry_controller.sv | 173 +++++++++++++++++
 tb/tb_keypad_entry_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the keypad entry path: entry states, key codes, opCode encoding.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_ENTER_A     = 2'd0,
        ST_ENTER_B     = 2'd1,
        ST_WAIT_CALC   = 2'd2,
        ST_SHOW_RESULT = 2'd3
    } state_e;

    localparam logic [4:0] KEY_PLUS   = 5'd10;
    localparam logic [4:0] KEY_MINUS  = 5'd11;
    localparam logic [4:0] KEY_MUL    = 5'd12;
    localparam logic [4:0] KEY_DIV    = 5'd13;
    localparam logic [4:0] KEY_EQUALS = 5'd14;
    localparam logic [4:0] KEY_CLEAR  = 5'd15;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    // Operator keys are contiguous, so the opCode is the offset from KEY_PLUS.
    function automatic logic [1:0] key_to_op(input logic [4:0] key);
        logic [4:0] diff;
        diff = key - KEY_PLUS;
        return diff[1:0];
    endfunction

    function automatic logic [13:0] append_digit(input logic [13:0] cur, input logic [4:0] key);
        return (cur * 14'd10) + {9'd0, key};
    endfunction

endpackage

// File: rtl/entry_timeout_counter.sv
// Idle-cycle counter that flags expiry after TIMEOUT_CYCLES unrestarted cycles.
// Expiry is combinational from the count; the count holds while hold is high.
module entry_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    input  logic hold,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = !hold && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (restart || expired) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_entry_controller.sv
// Builds two decimal operands and an operator from key presses and hands them to a calculator.
// One-cycle key latency; keys during a pending calculation are dropped; idle auto-clear under KEY_TIMEOUT_EN.
module keypad_entry_controller
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned MAX_DIGITS     = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        validPress,
    input  logic [4:0]  button,
    output logic        scanEnable,
    output logic [13:0] operandA,
    output logic [13:0] operandB,
    output logic [1:0]  opCode,
    output logic        calcStart,
    input  logic        calcDone,
    input  logic [13:0] calcResult,
    input  logic        calcError,
    output logic [1:0]  displaySel
);
    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    state_e           state_q, state_d;
    logic [13:0]      opa_q, opa_d;
    logic [13:0]      opb_q, opb_d;
    logic [13:0]      res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] na_q, na_d;
    logic [CNT_W-1:0] nb_q, nb_d;
    logic             err_q, err_d;
    logic             start_q, start_d;

    logic key_vld, is_digit, is_op, is_eq, is_clr;
    logic tmo_expired;

    assign key_vld  = validPress && (state_q != ST_WAIT_CALC);
    assign is_digit = (button <= 5'd9);
    assign is_op    = (button >= KEY_PLUS) && (button <= KEY_DIV);
    assign is_eq    = (button == KEY_EQUALS);
    assign is_clr   = (button == KEY_CLEAR);

`ifdef KEY_TIMEOUT_EN
    logic tmo_restart;
    assign tmo_restart = key_vld || (state_d != state_q);

    entry_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .restart (tmo_restart),
        .hold    (state_q == ST_WAIT_CALC),
        .expired (tmo_expired)
    );
`else
    // The timeout length only matters when the idle counter is built in.
    assign tmo_expired = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        op_d    = op_q;
        na_d    = na_q;
        nb_d    = nb_q;
        err_d   = err_q;
        start_d = 1'b0;

        unique case (state_q)
            ST_ENTER_A: begin
                if (key_vld && is_digit && (na_q < CNT_MAX)) begin
                    opa_d = append_digit(opa_q, button);
                    na_d  = na_q + 1'b1;
                end else if (key_vld && is_op && (na_q != '0)) begin
                    op_d    = key_to_op(button);
                    state_d = ST_ENTER_B;
                end
            end
            ST_ENTER_B: begin
                if (key_vld && is_digit && (nb_q < CNT_MAX)) begin
                    opb_d = append_digit(opb_q, button);
                    nb_d  = nb_q + 1'b1;
                end else if (key_vld && is_op && (nb_q == '0)) begin
                    op_d = key_to_op(button);
                end else if (key_vld && is_eq && (nb_q != '0)) begin
                    state_d = ST_WAIT_CALC;
                    start_d = 1'b1;
                end
            end
            ST_WAIT_CALC: begin
                if (calcDone) begin
                    res_d   = calcResult;
                    err_d   = calcError;
                    state_d = ST_SHOW_RESULT;
                end
            end
            ST_SHOW_RESULT: begin
                if (key_vld && is_digit) begin
                    opa_d   = {9'd0, button};
                    opb_d   = '0;
                    na_d    = CNT_W'(1);
                    nb_d    = '0;
                    err_d   = 1'b0;
                    state_d = ST_ENTER_A;
                end else if (key_vld && is_op && !err_q) begin
                    // Chaining: the result becomes a fully-entered operand A.
                    opa_d   = res_q;
                    opb_d   = '0;
                    op_d    = key_to_op(button);
                    na_d    = CNT_MAX;
                    nb_d    = '0;
                    state_d = ST_ENTER_B;
                end
            end
        endcase

        // A key coinciding with expiry wins over the auto-clear.
        if ((key_vld && is_clr) || (tmo_expired && !validPress)) begin
            opa_d   = '0;
            opb_d   = '0;
            op_d    = OP_ADD;
            na_d    = '0;
            nb_d    = '0;
            err_d   = 1'b0;
            state_d = ST_ENTER_A;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ENTER_A;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            op_q    <= OP_ADD;
            na_q    <= '0;
            nb_q    <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            op_q    <= op_d;
            na_q    <= na_d;
            nb_q    <= nb_d;
            err_q   <= err_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        scanEnable = (state_q != ST_WAIT_CALC);
        calcStart  = start_q;
        operandA   = opa_q;
        operandB   = opb_q;
        opCode     = op_q;
        displaySel = 2'd0;
        unique case (state_q)
            ST_ENTER_A:     displaySel = 2'd0;
            ST_ENTER_B:     displaySel = 2'd1;
            ST_WAIT_CALC:   displaySel = 2'd1;
            ST_SHOW_RESULT: displaySel = err_q ? 2'd3 : 2'd2;
        endcase
    end

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Directed plus random key sequences checked against a behavioural calculator-entry model.
module tb_keypad_entry_controller;
    localparam int MAXD = 4;
    localparam int TO   = 16;
    localparam int M_A = 0, M_B = 1, M_WAIT = 2, M_SHOW = 3;

    logic        clock;
    logic        reset_n;
    logic        validPress;
    logic [4:0]  button;
    logic        scanEnable;
    logic [13:0] operandA, operandB;
    logic [1:0]  opCode;
    logic        calcStart;
    logic        calcDone;
    logic [13:0] calcResult;
    logic        calcError;
    logic [1:0]  displaySel;

    keypad_entry_controller #(
        .TIMEOUT_CYCLES(TO),
        .MAX_DIGITS(MAXD)
    ) dut (
        .clock(clock), .reset_n(reset_n), .validPress(validPress), .button(button),
        .scanEnable(scanEnable), .operandA(operandA), .operandB(operandB), .opCode(opCode),
        .calcStart(calcStart), .calcDone(calcDone), .calcResult(calcResult),
        .calcError(calcError), .displaySel(displaySel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int m_mode, m_a, m_b, m_op, m_na, m_nb, m_res, m_idle;
    bit m_err, m_start;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_disp();
        if (m_mode == M_A) return 0;
        if (m_mode == M_B) return 1;
        return m_err ? 3 : 2;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".operandA"}, 32'(operandA), m_a);
        check({tag, ".operandB"}, 32'(operandB), m_b);
        check({tag, ".opCode"}, 32'(opCode), m_op);
        check({tag, ".scanEnable"}, 32'(scanEnable), (m_mode != M_WAIT) ? 1 : 0);
        check({tag, ".calcStart"}, 32'(calcStart), m_start ? 1 : 0);
        if (m_mode != M_WAIT) check({tag, ".displaySel"}, 32'(displaySel), exp_disp());
    endtask

    function automatic void model_clear();
        m_a = 0; m_b = 0; m_op = 0; m_na = 0; m_nb = 0; m_err = 0; m_mode = M_A;
    endfunction

    function automatic void model_key(input int k);
        if (m_mode == M_WAIT || k > 15) return;
        if (k == 15) begin
            model_clear();
        end else if (k <= 9) begin
            if (m_mode == M_A && m_na < MAXD) begin
                m_a = m_a * 10 + k; m_na++;
            end else if (m_mode == M_B && m_nb < MAXD) begin
                m_b = m_b * 10 + k; m_nb++;
            end else if (m_mode == M_SHOW) begin
                m_a = k; m_b = 0; m_na = 1; m_nb = 0; m_mode = M_A;
            end
        end else if (k <= 13) begin
            if (m_mode == M_A && m_na > 0) begin
                m_op = k - 10; m_mode = M_B;
            end else if (m_mode == M_B && m_nb == 0) begin
                m_op = k - 10;
            end else if (m_mode == M_SHOW && !m_err) begin
                m_a = m_res; m_b = 0; m_nb = 0; m_op = k - 10; m_mode = M_B;
            end
        end else if (m_mode == M_B && m_nb > 0) begin
            m_mode = M_WAIT;
        end
    endfunction

    // One clock: drive at the falling edge, update the model, check after the rising edge.
    task automatic step(input string tag, input bit vp, input int k,
                        input bit done, input int res, input bit err);
        int prev;
        @(negedge clock);
        validPress = vp; button = 5'(k); calcDone = done;
        calcResult = 14'(res); calcError = err;
        @(posedge clock);
        #1;
        validPress = 1'b0; calcDone = 1'b0;
        prev = m_mode;
        if (vp) model_key(k);
        if (done && prev == M_WAIT) begin
            m_res = res; m_err = err; m_mode = M_SHOW;
        end
`ifdef KEY_TIMEOUT_EN
        if (prev == M_WAIT) begin
            if (m_mode != prev) m_idle = 0;
        end else if (vp || m_mode != prev) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                model_clear(); m_idle = 0;
            end
        end
`endif
        m_start = (m_mode == M_WAIT) && (prev != M_WAIT);
        check_outputs(tag);
    endtask

    task automatic press(input string tag, input int k);
        step(tag, 1'b1, k, 1'b0, 0, 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, k;
        reset_n = 1'b1; validPress = 1'b0; button = '0;
        calcDone = 1'b0; calcResult = '0; calcError = 1'b0;
        model_clear(); m_res = 0; m_start = 0; m_idle = 0;
        #3 reset_n = 1'b0;
        #1 check_outputs("reset_async");
        repeat (2) @(posedge clock);
        #1 check_outputs("reset_held");
        @(negedge clock) reset_n = 1'b1;

        // Test 1: 12 + 34 = 46
        press("t1", 1); press("t1", 2); press("t1", KEY_PLUS_I());
        press("t1", 3); press("t1", 4); press("t1_eq", 14);
        check("t1_start_pulse", 32'(calcStart), 1);
        check("t1_opA", 32'(operandA), 12);
        check("t1_opB", 32'(operandB), 34);
        idle("t1_wait");
        check("t1_start_once", 32'(calcStart), 0);
        step("t1_done", 1'b0, 0, 1'b1, 46, 1'b0);
        check("t1_disp", 32'(displaySel), 2);

        // Test 5: chain from result 46
        press("t5", 10);
        check("t5_opA", 32'(operandA), 46);
        check("t5_dispB", 32'(displaySel), 1);
        press("t5_clr", 15);

        // Test 2: fifth digit ignored
        for (int i = 0; i < 5; i++) press("t2", 9);
        check("t2_opA", 32'(operandA), 9999);
        press("t2_clr", 15);

        // Test 3: operators and = with no digits, then operator replacement
        press("t3", 10); press("t3", 14);
        check("t3_still_A", 32'(displaySel), 0);
        press("t3", 5); press("t3", 11); press("t3", 12);
        check("t3_op", 32'(opCode), 2);
        check("t3_in_B", 32'(displaySel), 1);
        press("t3_clr", 15);

        // Test 4: keys ignored while waiting, error result, clear
        press("t4", 1); press("t4", 10); press("t4", 2); press("t4", 14);
        press("t4_wait", 3); press("t4_wait", 15); press("t4_wait", 10);
        check("t4_scan", 32'(scanEnable), 0);
        check("t4_opB_kept", 32'(operandB), 2);
        step("t4_done", 1'b0, 0, 1'b1, 5, 1'b1);
        check("t4_disp_err", 32'(displaySel), 3);
        press("t4_op_ignored", 10);
        check("t4_still_err", 32'(displaySel), 3);
        press("t4_clr", 15);
        check("t4_clr_opA", 32'(operandA), 0);
        check("t4_clr_disp", 32'(displaySel), 0);

        // Test 6: reset during WAIT_CALC aborts the calculation
        press("t6", 7); press("t6", 12); press("t6", 8); press("t6", 14);
        idle("t6_wait");
        #2 reset_n = 1'b0;
        model_clear(); m_start = 0; m_idle = 0;
        #1 check_outputs("t6_reset");
        check("t6_disp_A", 32'(displaySel), 0);
        @(negedge clock) reset_n = 1'b1;
        step("t6_late_done", 1'b0, 0, 1'b1, 56, 1'b0);
        check("t6_ignored", 32'(displaySel), 0);

`ifdef KEY_TIMEOUT_EN
        // Test 7: auto-clear after TO idle cycles; a key on the last cycle wins
        press("t7", 7);
        for (int i = 0; i < TO - 1; i++) idle("t7_idle");
        check("t7_not_yet", 32'(operandA), 7);
        idle("t7_expire");
        check("t7_cleared", 32'(operandA), 0);
        press("t7b", 7);
        for (int i = 0; i < TO - 1; i++) idle("t7b_idle");
        press("t7b_key", 3);
        check("t7b_kept", 32'(operandA), 73);
        press("t7_clr", 15);
`endif

        // Random phase against the model
        for (int i = 0; i < 400; i++) begin
            if (m_mode == M_WAIT) begin
                step("rnd_wait", $urandom_range(0, 1) == 1, $urandom_range(0, 31),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 9999),
                     $urandom_range(0, 3) == 0);
            end else begin
                r = $urandom_range(0, 99);
                if (r < 55)      k = $urandom_range(0, 9);
                else if (r < 80) k = $urandom_range(10, 13);
                else if (r < 88) k = 14;
                else if (r < 92) k = 15;
                else             k = $urandom_range(16, 31);
                step("rnd", $urandom_range(0, 3) != 0, k, 1'b0, 0, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    function automatic int KEY_PLUS_I();
        return 10;
    endfunction

endmodule
